// File: rtl/pzcorebus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pzcorebus_pkg : command types and classification helpers for pzcorebus     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
package pzcorebus_pkg;

    typedef enum logic [3:0] {
        PZCOREBUS_NULL               = 4'h0,
        PZCOREBUS_WRITE              = 4'h1,
        PZCOREBUS_WRITE_NON_POSTED   = 4'h2,
        PZCOREBUS_READ               = 4'h3,
        PZCOREBUS_ATOMIC             = 4'h4,
        PZCOREBUS_MESSAGE            = 4'h5,
        PZCOREBUS_MESSAGE_NON_POSTED = 4'h6,
        PZCOREBUS_BROADCAST          = 4'h7
    } pzcorebus_command_type;

    // Commands that produce a response and therefore occupy an outstanding slot.
    function automatic logic is_non_posted_command(input pzcorebus_command_type cmd);
        logic result;
        case (cmd)
            PZCOREBUS_READ,
            PZCOREBUS_WRITE_NON_POSTED,
            PZCOREBUS_ATOMIC,
            PZCOREBUS_MESSAGE_NON_POSTED,
            PZCOREBUS_BROADCAST:          result = 1'b1;
            default:                      result = 1'b0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pzcorebus_1_to_m_switch_order_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pzcorebus_1_to_m_switch_order_controller : keeps 1-to-M switch responses    |
// | in order by locking one target while non-posted commands are in flight.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module pzcorebus_1_to_m_switch_order_controller
    import pzcorebus_pkg::*;
#(
    parameter int MASTERS         = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_mcmd_valid,
    input  pzcorebus_command_type  i_mcmd,
    input  logic [MASTERS-1:0]     i_select,
    input  logic                   i_scmd_accept,
    input  logic                   i_response_ack,
    input  logic                   i_response_last,
    output logic                   o_command_enable,
    output logic [MASTERS-1:0]     o_locked_select,
    output logic [COUNT_WIDTH-1:0] o_outstanding,
    output logic                   o_busy,
    output logic                   o_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } pzcorebus_order_state;

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_OUTSTANDING);

    pzcorebus_order_state   state;
    pzcorebus_order_state   state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [MASTERS-1:0]     locked_select;
    logic [MASTERS-1:0]     locked_next;
    logic [MASTERS-1:0]     target;
    logic                   non_posted;
    logic                   same_target;
    logic                   command_enable;
    logic                   cmd_ack;
    logic                   resp_done;
    logic                   increment;
    logic                   decrement;
    logic                   error;

    // A broadcast reaches every master, so it is tracked as an all-ones target.
    assign non_posted  = is_non_posted_command(i_mcmd);
    assign target      = (i_mcmd == PZCOREBUS_BROADCAST) ? '1 : i_select;
    assign same_target = (target == locked_select);

    always_comb begin
        command_enable = 1'b0;
        case (state)
            IDLE:    command_enable = 1'b1;
            ACTIVE:  command_enable = !non_posted || (same_target && (count != MAX_COUNT));
            DRAIN:   command_enable = !non_posted;
            default: command_enable = 1'b0;
        endcase
    end

    assign cmd_ack   = i_mcmd_valid && command_enable && i_scmd_accept;
    assign resp_done = i_response_ack && i_response_last;
    assign increment = cmd_ack && non_posted;
    assign decrement = resp_done && (count != '0);

    always_comb begin
        count_next = count;
        case ({increment, decrement})
            2'b10:   count_next = count + COUNT_WIDTH'(1);
            2'b01:   count_next = count - COUNT_WIDTH'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next  = state;
        locked_next = locked_select;
        case (state)
            IDLE: begin
                if (increment) begin
                    state_next  = ACTIVE;
                    locked_next = target;
                end
            end
            ACTIVE: begin
                if (count_next == '0) begin
                    state_next  = IDLE;
                    locked_next = '0;
                end else if (i_mcmd_valid && non_posted && !same_target) begin
                    state_next  = DRAIN;
                end
            end
            DRAIN: begin
                if (count_next == '0) begin
                    state_next  = IDLE;
                    locked_next = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                locked_next = '0;
            end
        endcase
    end

    // A completed response with nothing outstanding is a protocol violation.
    assign error = resp_done && (count == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            count         <= '0;
            locked_select <= '0;
            o_error       <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            locked_select <= locked_next;
            o_error       <= error;
        end
    end

    assign o_command_enable = command_enable;
    assign o_locked_select  = locked_select;
    assign o_outstanding    = count;
    assign o_busy           = (count != '0);

endmodule
`default_nettype wire
